if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC, drives the instruction-memory address and latches {PC+4, instruction} into IF/ID.
- Consumes the ID-stage hazard outputs (branchbubble, load-use bubble) and the ID-resolved branch/jump redirects.
- Stalls, redirects or flushes accordingly. No branch delay slot: a taken redirect squashes the wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, encoding inserted into IF/ID on flush and reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- branchbubble  input  1  ID branch operand hazard; stall fetch.
- loaduse_bubble  input  1  load-use hazard; stall fetch.
- id_branch_taken  input  1  ID resolved a conditional branch (beq/bne/bgez/bgtz/blez/bltz) as taken.
- id_branch_target  input  32  branch target.
- id_jump  input  1  j/jal in ID.
- id_jump_target  input  32  jump target.
- id_jr  input  1  jr/jalr in ID.
- id_jr_target  input  32  forwarded rs value.
- imem_addr  output  32  instruction memory address; equals pc.
- imem_inst  input  32  instruction, combinational read of imem_addr.
- if_id_pc4  output  32  registered PC+4 of the instruction in ID.
- if_id_inst  output  32  registered instruction in ID.
- if_id_valid  output  1  IF/ID holds a real (non-squashed) instruction.
- stall_cnt  output  32  stall-cycle counter (see Optional Feature).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge.
- Internal state: pc[31:0]. imem_addr = pc, combinational.
- stall = branchbubble | loaduse_bubble.
- redirect = id_jr | id_jump | id_branch_taken.
- Target select priority: id_jr > id_jump > id_branch_taken. Selected target has bits[1:0] forced to 2'b00.
- Per-edge priority:
  - rst: pc <= RESET_PC; if_id_inst <= NOP_INST; if_id_pc4 <= 0; if_id_valid <= 0; stall_cnt <= 0.
  - else stall: pc, if_id_inst, if_id_pc4 and if_id_valid all hold. Redirect inputs are ignored because the ID decision uses stale operands. The redirect is re-evaluated on the first non-stall cycle.
  - else redirect: pc <= target. IF/ID flushed: if_id_inst <= NOP_INST, if_id_pc4 <= pc+4, if_id_valid <= 0.
  - else sequential: pc <= pc+4; if_id_inst <= imem_inst; if_id_pc4 <= pc+4; if_id_valid <= 1.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no flag.
- Latency: an instruction fetched at cycle N is presented on if_id_* at N+1. Redirect penalty is exactly one squashed slot.
- Stall and redirect in the same cycle: stall wins; pc is unchanged.
- Reset asserted mid-stall or mid-redirect: reset wins; the next cycle fetches RESET_PC.
- First cycle after reset release: if_id_valid = 0, if_id_inst = NOP_INST; IF/ID loads the RESET_PC instruction on that edge.

Optional Feature:
- Macro: IF_FETCH_STALLCNT_EN.
- Defined: stall_cnt increments by 1 on every non-reset edge with stall = 1. It saturates at 32'hFFFF_FFFF and is cleared by rst.
- Undefined: no counter register is built; stall_cnt is tied to 32'h0. All other behaviour is identical.

Test Plan:
- Reset then 3 free cycles, imem returns 0x1111_0000+addr -> pc steps 0x3000, 0x3004, 0x3008, 0x300C. if_id_inst lags pc by one cycle; if_id_valid rises one cycle after rst release.
- branchbubble=1 for 2 cycles at pc=0x3008 with id_branch_taken=1 also high -> pc and IF/ID hold for both cycles. On release with taken still high: pc <= target, if_id_valid=0. stall_cnt=2 with macro, 0 without.
- id_branch_taken=1, target=0x3103 -> pc <= 0x3100 (low bits cleared), if_id_inst=NOP_INST, if_id_valid=0, if_id_pc4 = old pc+4.
- id_jr=1 (0x4000) and id_jump=1 (0x5000) together -> pc <= 0x4000.
- Force pc to 0xFFFF_FFFC via jr, then one free cycle -> pc=0x0000_0000, if_id_pc4=0x0000_0000.
- rst asserted during loaduse_bubble=1 -> next edge pc=RESET_PC, if_id_valid=0, stall_cnt=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage and IF/ID pipeline register of a 5-stage MIPS core.
//
// The stage holds the program counter, presents it to the instruction memory,
// and on each rising edge does one of the following:
//   - latches {pc+4, fetched instruction} into IF/ID and advances pc,
//   - holds everything while the ID stage reports a hazard, or
//   - redirects pc to an ID-resolved branch/jump target and squashes the
//     wrong-path fetch.
// The core has no branch delay slot, so every taken redirect costs exactly one
// squashed IF/ID slot.
//
// Parameters:
//   RESET_PC  PC loaded on reset.
//   NOP_INST  Encoding written into IF/ID on reset and on a squash.
//
// Ports:
//   clk               in   system clock, rising edge
//   rst               in   synchronous active-high reset
//   branchbubble      in   ID branch-operand hazard, stalls fetch
//   loaduse_bubble    in   load-use hazard, stalls fetch
//   id_branch_taken   in   conditional branch in ID resolved taken
//   id_branch_target  in   [31:0] branch target
//   id_jump           in   j/jal in ID
//   id_jump_target    in   [31:0] jump target
//   id_jr             in   jr/jalr in ID
//   id_jr_target      in   [31:0] forwarded rs value
//   imem_addr         out  [31:0] instruction-memory address (== pc)
//   imem_inst         in   [31:0] combinational read data for imem_addr
//   if_id_pc4         out  [31:0] PC+4 of the instruction held in IF/ID
//   if_id_inst        out  [31:0] instruction held in IF/ID
//   if_id_valid       out  IF/ID holds a real, non-squashed instruction
//   stall_cnt         out  [31:0] saturating count of stalled edges
//
// Build option:
//   IF_FETCH_STALLCNT_EN  When defined, stall_cnt is a saturating 32-bit
//                         counter of stalled (non-reset) edges, cleared by
//                         rst. When undefined, no counter is built and
//                         stall_cnt is tied to zero.
// ============================================================================

`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,

  // Hazard inputs from ID
  input  logic        branchbubble,
  input  logic        loaduse_bubble,

  // Redirect requests from ID
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_target,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        id_jr,
  input  logic [31:0] id_jr_target,

  // Instruction memory
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,

  // IF/ID pipeline register
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,

  // Diagnostics
  output logic [31:0] stall_cnt
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] pc;

  // --------------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------------
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  assign stall    = branchbubble | loaduse_bubble;
  assign redirect = id_jr | id_jump | id_branch_taken;

  // 32-bit modulo add: 32'hFFFF_FFFC wraps to zero silently.
  assign pc_plus4 = pc + 32'd4;

  // jr beats jump beats branch. The word-alignment bits are cleared here so a
  // misaligned register value (jr) can never put pc off a word boundary.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    redirect_target = id_branch_target;
    if (id_jr) begin
      redirect_target = id_jr_target;
    end else if (id_jump) begin
      redirect_target = id_jump_target;
    end
    redirect_target[1:0] = 2'b00;
  end

  assign imem_addr = pc;

  // --------------------------------------------------------------------------
  // PC and IF/ID register
  // --------------------------------------------------------------------------
  // A stall takes precedence over a redirect: while ID is stalled its branch
  // decision is based on stale operands, so the redirect is simply dropped and
  // ID re-presents it on the first cycle the stall is gone.
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
      if_id_inst  <= if_id_inst;
      if_id_pc4   <= if_id_pc4;
      if_id_valid <= if_id_valid;
    end else if (redirect) begin
      // The instruction fetched this cycle is on the wrong path: squash it.
      pc          <= redirect_target;
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_plus4;
      if_id_inst  <= imem_inst;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stall counter (optional)
  // --------------------------------------------------------------------------
`ifdef IF_FETCH_STALLCNT_EN
  logic [31:0] stall_cnt_q;

  // Saturates instead of wrapping so a long-running count never reads as
  // a small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage
// ----------------------------------------------------------------------------
// Self-checking bench for if_fetch_stage. A directed table walks the reset,
// stall, redirect, priority and wrap-around cases; a randomized phase then
// drives arbitrary hazard/redirect/reset mixes against a reference model that
// applies the fetch rules directly to a small architectural state record.
// ============================================================================

`timescale 1ns/1ps

module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

`ifdef IF_FETCH_STALLCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        branchbubble, loaduse_bubble;
  logic        id_branch_taken, id_jump, id_jr;
  logic [31:0] id_branch_target, id_jump_target, id_jr_target;
  logic [31:0] imem_addr, imem_inst;
  logic [31:0] if_id_pc4, if_id_inst, stall_cnt;
  logic        if_id_valid;

  always #5 clk = ~clk;

  // Instruction memory: every word is 0x1111_0000 + its address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  assign imem_inst = imem_word(imem_addr);

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .branchbubble     (branchbubble),
    .loaduse_bubble   (loaduse_bubble),
    .id_branch_taken  (id_branch_taken),
    .id_branch_target (id_branch_target),
    .id_jump          (id_jump),
    .id_jump_target   (id_jump_target),
    .id_jr            (id_jr),
    .id_jr_target     (id_jr_target),
    .imem_addr        (imem_addr),
    .imem_inst        (imem_inst),
    .if_id_pc4        (if_id_pc4),
    .if_id_inst       (if_id_inst),
    .if_id_valid      (if_id_valid),
    .stall_cnt        (stall_cnt)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s (vector %0d): got %08h, expected %08h",
               name, n_vectors, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, bb, lu, bt;
    logic [31:0] btgt;
    logic        j;
    logic [31:0] jtgt;
    logic        jr;
    logic [31:0] jrtgt;
    logic [31:0] e_pc, e_inst, e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;    // expected count when the counter is built
  } vec_t;

  task automatic drive(input vec_t v);
    rst              = v.rst;
    branchbubble     = v.bb;
    loaduse_bubble   = v.lu;
    id_branch_taken  = v.bt;
    id_branch_target = v.btgt;
    id_jump          = v.j;
    id_jump_target   = v.jtgt;
    id_jr            = v.jr;
    id_jr_target     = v.jrtgt;
  endtask

  // Drives on the falling edge, samples 1 ns after the rising edge.
  task automatic apply_and_check(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    n_vectors++;
    check("imem_addr",   imem_addr,          v.e_pc);
    check("if_id_inst",  if_id_inst,         v.e_inst);
    check("if_id_pc4",   if_id_pc4,          v.e_pc4);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, v.e_valid});
    check("stall_cnt",   stall_cnt,          CNT_EN ? v.e_cnt : 32'h0);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: architectural state after each edge
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc, inst, pc4;
    logic        valid;
    longint      cnt;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t s, input vec_t v);
    model_t      n = s;
    logic [31:0] tgt;
    if (v.rst) begin
      n.pc = RESET_PC; n.inst = NOP_INST; n.pc4 = 0; n.valid = 0; n.cnt = 0;
    end else if (v.bb || v.lu) begin
      if (s.cnt < 64'h0000_0000_FFFF_FFFF) n.cnt = s.cnt + 1;
    end else if (v.jr || v.j || v.bt) begin
      tgt      = v.jr ? v.jrtgt : (v.j ? v.jtgt : v.btgt);
      n.pc     = tgt & ~32'h3;
      n.inst   = NOP_INST;
      n.pc4    = s.pc + 4;
      n.valid  = 0;
    end else begin
      n.inst  = imem_word(s.pc);
      n.pc4   = s.pc + 4;
      n.pc    = s.pc + 4;
      n.valid = 1;
    end
    return n;
  endfunction

  function automatic vec_t random_vec();
    vec_t v;
    v.rst   = ($urandom_range(63) == 0);
    v.bb    = ($urandom_range(5) == 0);
    v.lu    = ($urandom_range(5) == 0);
    v.bt    = ($urandom_range(4) == 0);
    v.j     = ($urandom_range(6) == 0);
    v.jr    = ($urandom_range(7) == 0);
    v.btgt  = $urandom();
    v.jtgt  = $urandom();
    v.jrtgt = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom();
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  vec_t vecs[$];

  initial begin
    drive('{default: '0});
    rst = 1'b1;

    //                 rst   bb    lu    bt    btgt          j     jtgt          jr    jrtgt         e_pc          e_inst        e_pc4         valid cnt
    // Reset, then free-running fetch.
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3000, NOP_INST,     32'h0,        1'b0, 32'd0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3004, 32'h1111_3000, 32'h0000_3004, 1'b1, 32'd0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3008, 32'h1111_3004, 32'h0000_3008, 1'b1, 32'd0});
    // Two-cycle branchbubble with a taken branch pending: everything holds.
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 32'h3200,     1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3008, 32'h1111_3004, 32'h0000_3008, 1'b1, 32'd1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 32'h3200,     1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3008, 32'h1111_3004, 32'h0000_3008, 1'b1, 32'd2});
    // Stall released, branch still taken: redirect and squash.
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 32'h3200,     1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3200, NOP_INST,     32'h0000_300C, 1'b0, 32'd2});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3204, 32'h1111_3200, 32'h0000_3204, 1'b1, 32'd2});
    // Misaligned branch target: low bits cleared.
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 32'h3103,     1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3100, NOP_INST,     32'h0000_3208, 1'b0, 32'd2});
    // jr beats jump.
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h5000,     1'b1, 32'h4000,     32'h0000_4000, NOP_INST,     32'h0000_3104, 1'b0, 32'd2});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_4004, 32'h1111_4000, 32'h0000_4004, 1'b1, 32'd2});
    // jr to the top word (misaligned value), then wrap to zero.
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, NOP_INST,     32'h0000_4008, 1'b0, 32'd2});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 32'h1110_FFFC, 32'h0000_0000, 1'b1, 32'd2});
    // jump beats branch.
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 32'h6000,     1'b1, 32'h5001,     1'b0, 32'h0,        32'h0000_5000, NOP_INST,     32'h0000_0004, 1'b0, 32'd2});
    // Load-use stall, then reset during the stall.
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_5000, NOP_INST,     32'h0000_0004, 1'b0, 32'd3});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1, 32'h7000,     1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3000, NOP_INST,     32'h0,        1'b0, 32'd0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_3004, 32'h1111_3000, 32'h0000_3004, 1'b1, 32'd0});

    foreach (vecs[i]) apply_and_check(vecs[i]);

    // Randomized phase against the reference model, starting from reset.
    m = '{pc: 32'h0, inst: 32'h0, pc4: 32'h0, valid: 1'b0, cnt: 0};
    for (int i = 0; i < 3000; i++) begin
      vec_t v = random_vec();
      if (i == 0) v.rst = 1'b1;
      m = model_step(m, v);
      v.e_pc    = m.pc;
      v.e_inst  = m.inst;
      v.e_pc4   = m.pc4;
      v.e_valid = m.valid;
      v.e_cnt   = m.cnt[31:0];
      apply_and_check(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
